// File: rtl/stream_demux_1ton_pkg.sv
// Shared definitions for the 1-to-N stream demultiplexer: FSM encodings and
// default widths.
package stream_demux_1ton_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROUTE = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 8;
endpackage

// File: rtl/stream_reg_slice.sv
// One-beat registered output slice {valid, data, last}; a write replaces a
// draining beat in the same cycle so a streaming channel never bubbles.
module stream_reg_slice #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              can_accept
);
  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic              last_p1;

  assign can_accept = !vld_p1 || out_ready;

  // Stage p1: slice register
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
    end else if (wr_en && can_accept) begin
      vld_p1  <= 1'b1;
      data_p1 <= wr_data;
      last_p1 <= wr_last;
    end else if (vld_p1 && out_ready) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_last  = last_p1;
endmodule

// File: rtl/stream_demux_1ton.sv
// 1-to-N packet demultiplexer: the channel is locked on the first beat of a
// packet; packets to a non-existent channel are swallowed and counted.
module stream_demux_1ton
  import stream_demux_1ton_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int CNT_W  = DEF_CNT_W,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_last,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_last,
  output logic [CNT_W-1:0]         drop_cnt
);
  logic [1:0]       state_q, state_d;
  logic [SEL_W-1:0] cur_ch;
  logic [CNT_W-1:0] drop_cnt_q;
  logic [SEL_W-1:0] tgt;
  logic             sel_ok, route_beat, accept, tgt_can;
  logic [NUM_CH-1:0] can_acc, wr_en;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  assign sel_ok     = ({1'b0, in_sel} < (SEL_W+1)'(NUM_CH));
  assign tgt        = (state_q == ST_IDLE) ? in_sel : cur_ch;
  assign route_beat = (state_q == ST_ROUTE) || (state_q == ST_IDLE && sel_ok);
  assign accept     = in_valid && in_ready;

  always_comb begin
    tgt_can = 1'b0;
    for (int k = 0; k < NUM_CH; k++)
      if (SEL_W'(k) == tgt) tgt_can = can_acc[k];
  end

  // Discarding states always sink; routing follows the target slice.
  always_comb begin
    in_ready = tgt_can;
    if (state_q == ST_DROP || (state_q == ST_IDLE && !sel_ok)) in_ready = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept && !in_last) state_d = sel_ok ? ST_ROUTE : ST_DROP;
      ST_ROUTE,
      ST_DROP:  if (accept && in_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Stage p0: packet control
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cur_ch     <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept && state_q == ST_IDLE) begin
        if (sel_ok) cur_ch     <= in_sel;
        else        drop_cnt_q <= sat_inc(drop_cnt_q);
      end
    end
  end

  assign drop_cnt = drop_cnt_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign wr_en[k] = accept && route_beat && (tgt == SEL_W'(k));

    stream_reg_slice #(.DATA_W(DATA_W)) u_slice (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en[k]),
      .wr_data   (in_data),
      .wr_last   (in_last),
      .out_valid (out_valid[k]),
      .out_ready (out_ready[k]),
      .out_data  (out_data[k*DATA_W +: DATA_W]),
      .out_last  (out_last[k]),
      .can_accept(can_acc[k])
    );
  end
endmodule

// File: tb/tb_stream_demux_1ton.sv
// Scoreboard bench: a 4-channel and a 3-channel demux driven with directed
// packets; a monitor pops expected {last,data} per channel on each handshake.
module tb_stream_demux_1ton;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4, iv4, ir4, il4;
  logic [7:0]  id4;
  logic [1:0]  is4;
  logic [3:0]  ov4, or4, ol4;
  logic [31:0] od4;
  logic [7:0]  dc4;

  logic        rst3, iv3, ir3, il3;
  logic [7:0]  id3;
  logic [1:0]  is3;
  logic [2:0]  ov3, or3, ol3;
  logic [23:0] od3;
  logic [7:0]  dc3;

  stream_demux_1ton #(.NUM_CH(4), .DATA_W(8), .CNT_W(8)) dut4 (
    .clk(clk), .rst(rst4), .in_valid(iv4), .in_ready(ir4), .in_data(id4),
    .in_sel(is4), .in_last(il4), .out_valid(ov4), .out_ready(or4),
    .out_data(od4), .out_last(ol4), .drop_cnt(dc4));

  stream_demux_1ton #(.NUM_CH(3), .DATA_W(8), .CNT_W(8)) dut3 (
    .clk(clk), .rst(rst3), .in_valid(iv3), .in_ready(ir3), .in_data(id3),
    .in_sel(is3), .in_last(il3), .out_valid(ov3), .out_ready(or3),
    .out_data(od3), .out_last(ol3), .drop_cnt(dc3));

  // Queues 0..3: dut4 channels; 4..6: dut3 channels.
  logic [8:0] exp_q [7][$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one beat on dut d (0: 4-ch, 1: 3-ch); exp_ch < 0 means it must vanish.
  task automatic send(input int d, input logic [7:0] data, input logic [1:0] sel,
                      input logic last, input int exp_ch);
    int n = 0;
    logic rdy;
    if (d == 0) begin iv4 = 1'b1; id4 = data; is4 = sel; il4 = last; end
    else        begin iv3 = 1'b1; id3 = data; is3 = sel; il3 = last; end
    do begin
      @(negedge clk);
      n++;
      rdy = (d == 0) ? ir4 : ir3;
    end while (!rdy && n < 50);
    chk("handshake", {31'd0, rdy}, 32'd1);
    if (rdy && exp_ch >= 0) exp_q[exp_ch].push_back({last, data});
    @(posedge clk); #1;
    if (d == 0) iv4 = 1'b0; else iv3 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst4 = 1'b1; rst3 = 1'b1;
    iv4 = 1'b0; id4 = '0; is4 = '0; il4 = 1'b0; or4 = '1;
    iv3 = 1'b0; id3 = '0; is3 = '0; il3 = 1'b0; or3 = '1;

    fork
      forever begin
        @(negedge clk);
        for (int k = 0; k < 7; k++) begin
          logic       v;
          logic [8:0] beat, e;
          if (k < 4) begin
            v = ov4[k] && or4[k];
            beat = {ol4[k], od4[k*8 +: 8]};
          end else begin
            v = ov3[k-4] && or3[k-4];
            beat = {ol3[k-4], od3[(k-4)*8 +: 8]};
          end
          if (v) begin
            n_vec++;
            if (exp_q[k].size() == 0) begin
              n_err++;
              $display("FAIL beat_q%0d: got %h expected no beat", k, beat);
            end else begin
              e = exp_q[k].pop_front();
              if (beat !== e) begin
                n_err++;
                $display("FAIL beat_q%0d: got %h expected %h", k, beat, e);
              end
            end
          end
        end
      end
    join_none

    idle(2);
    rst4 = 1'b0; rst3 = 1'b0;
    @(negedge clk);
    chk("rst_ov4", {28'd0, ov4}, 32'd0);
    chk("rst_dc4", {24'd0, dc4}, 32'd0);
    chk("rst_ir4", {31'd0, ir4}, 32'd1);
    chk("rst_ov3", {29'd0, ov3}, 32'd0);
    chk("rst_dc3", {24'd0, dc3}, 32'd0);
    chk("rst_ir3", {31'd0, ir3}, 32'd1);
    @(posedge clk); #1;

    // 3-beat packet to channel 2
    send(0, 8'h11, 2'd2, 1'b0, 2);
    send(0, 8'h22, 2'd2, 1'b0, 2);
    send(0, 8'h33, 2'd2, 1'b1, 2);
    @(posedge clk); #1;
    chk("latency_ch2", exp_q[2].size(), 32'd0);

    // in_sel changes mid-packet are ignored
    send(0, 8'h41, 2'd1, 1'b0, 1);
    send(0, 8'h42, 2'd3, 1'b0, 1);
    send(0, 8'h43, 2'd3, 1'b0, 1);
    send(0, 8'h44, 2'd3, 1'b1, 1);
    idle(2);

    // Back-to-back single-beat packets to different channels
    send(0, 8'h01, 2'd0, 1'b1, 0);
    send(0, 8'h02, 2'd3, 1'b1, 3);
    send(0, 8'h03, 2'd1, 1'b0, 1);
    send(0, 8'h04, 2'd1, 1'b1, 1);
    idle(2);

    // Backpressure on channel 0
    or4[0] = 1'b0;
    send(0, 8'hB0, 2'd0, 1'b0, 0);
    iv4 = 1'b1; id4 = 8'hB1; is4 = 2'd0; il4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_ir4", {31'd0, ir4}, 32'd0);
      chk("stall_ov4", {28'd0, ov4}, 32'd1);
    end
    @(posedge clk); #1;
    or4[0] = 1'b1;
    send(0, 8'hB1, 2'd0, 1'b0, 0);
    send(0, 8'hB2, 2'd0, 1'b0, 0);
    send(0, 8'hB3, 2'd0, 1'b1, 0);
    idle(2);

    // NUM_CH=3: dropped 2-beat packet, then a good one
    send(1, 8'hD0, 2'd3, 1'b0, -1);
    send(1, 8'hD1, 2'd0, 1'b1, -1);
    chk("drop_dc3", {24'd0, dc3}, 32'd1);
    chk("drop_ov3", {29'd0, ov3}, 32'd0);
    send(1, 8'hA5, 2'd0, 1'b1, 4);
    idle(2);

    // Saturation of the drop counter
    for (int i = 0; i < 253; i++) send(1, 8'(i), 2'd3, 1'b1, -1);
    chk("dc3_254", {24'd0, dc3}, 32'd254);
    for (int i = 0; i < 47; i++) send(1, 8'(i), 2'd3, 1'b1, -1);
    chk("dc3_sat", {24'd0, dc3}, 32'd255);

    // Reset in the middle of a 5-beat packet
    send(1, 8'hC0, 2'd1, 1'b0, 5);
    send(1, 8'hC1, 2'd1, 1'b0, 5);
    rst3 = 1'b1;
    @(posedge clk); #1;
    rst3 = 1'b0;
    @(negedge clk);
    chk("rst_mid_ov3", {29'd0, ov3}, 32'd0);
    chk("rst_mid_dc3", {24'd0, dc3}, 32'd0);
    chk("rst_mid_ir3", {31'd0, ir3}, 32'd1);
    @(posedge clk); #1;
    send(1, 8'h5A, 2'd1, 1'b0, 5);
    send(1, 8'h5B, 2'd2, 1'b1, 5);
    idle(4);

    for (int k = 0; k < 7; k++) chk($sformatf("drain_q%0d", k), exp_q[k].size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
